// File: rtl/cordic_angle_reduce_if.sv
// Handshake bundle between the angle source, the reducer and the CORDIC cosine stage.
// The producer side uses the master modport; the reducer uses the slave modport.
interface cordic_angle_reduce_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [21:0] out_angle;
   logic        out_neg;
   logic        out_err;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_angle, out_neg, out_err
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_angle, out_neg, out_err
   );
endinterface

// File: rtl/cordic_angle_reduce.sv
// Reduces an IEEE-754 single angle modulo 2*pi and folds it into [0, pi/2] as Q2.20 plus a cosine negate flag.
// Optional macro CORDIC_REDUCE_SKIP_EN bypasses REDUCE when the aligned angle is already below 2*pi.
module cordic_angle_reduce #(
   parameter int MAX_EXP = 8
) (
   input logic                  clk,
   input logic                  reset,
   cordic_angle_reduce_if.slave bus
);

   localparam int W  = MAX_EXP + 31;
   localparam int KW = (MAX_EXP > 1) ? $clog2(MAX_EXP) : 1;

   localparam logic [W-1:0] TWO_PI  = W'(32'd1686629713);
   localparam logic [W-1:0] PI      = W'(32'd843314857);
   localparam logic [W-1:0] HALF_PI = W'(32'd421657428);
   localparam logic [W-1:0] RND     = W'(32'd128);

   typedef enum logic [2:0] {IDLE, ALIGN, REDUCE, FOLD, DONE} state_t;

   state_t         state_r;
   logic [W-1:0]   r_r;
   logic [KW-1:0]  k_r;
   logic [7:0]     exp_r;
   logic [22:0]    mant_r;
   logic           in_ready_r;
   logic           out_valid_r;
   logic [21:0]    out_angle_r;
   logic           out_neg_r;
   logic           out_err_r;

   logic [7:0]     in_exp_s;
   logic           in_bad_s;
   logic           in_tiny_s;
   logic [W-1:0]   sig_s;
   logic [W-1:0]   aligned_s;
   logic [W-1:0]   sub_s;
   logic [W-1:0]   reduced_s;
   logic [W-1:0]   r1_s;
   logic [W-1:0]   r2_s;
   logic           neg_s;
   logic [21:0]    angle_s;

   // Classify the incoming exponent: NaN/Inf/out-of-range versus flush-to-zero.
   always_comb begin
      in_exp_s  = bus.in_data[30:23];
      in_bad_s  = (in_exp_s == 8'hFF) || ({1'b0, in_exp_s} >= 9'(127 + MAX_EXP));
      in_tiny_s = (in_exp_s < 8'd99);
   end

   // Place the significand on the 28-fraction-bit grid; shift is e+5 = exp-122.
   always_comb begin
      sig_s = {{(W-24){1'b0}}, 1'b1, mant_r};
      if (exp_r >= 8'd122) begin
         aligned_s = sig_s << (exp_r - 8'd122);
      end else begin
         aligned_s = sig_s >> (8'd122 - exp_r);
      end
   end

   // One conditional subtraction of 2*pi scaled by 2^k.
   always_comb begin
      sub_s = TWO_PI << k_r;
      if (r_r >= sub_s) begin
         reduced_s = r_r - sub_s;
      end else begin
         reduced_s = r_r;
      end
   end

   // Fold [0, 2*pi) into [0, pi/2]; the pi-r1 reflection flips the cosine sign.
   always_comb begin
      if (r_r > PI) begin
         r1_s = TWO_PI - r_r;
      end else begin
         r1_s = r_r;
      end
      if (r1_s > HALF_PI) begin
         r2_s  = PI - r1_s;
         neg_s = 1'b1;
      end else begin
         r2_s  = r1_s;
         neg_s = 1'b0;
      end
      angle_s = 22'((r2_s + RND) >> 8);
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         r_r         <= '0;
         k_r         <= '0;
         exp_r       <= 8'd0;
         mant_r      <= 23'd0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_angle_r <= 22'd0;
         out_neg_r   <= 1'b0;
         out_err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  exp_r      <= in_exp_s;
                  mant_r     <= bus.in_data[22:0];
                  in_ready_r <= 1'b0;
                  if (in_bad_s) begin
                     out_angle_r <= 22'd0;
                     out_neg_r   <= 1'b0;
                     out_err_r   <= 1'b1;
                     out_valid_r <= 1'b1;
                     state_r     <= DONE;
                  end else if (in_tiny_s) begin
                     out_angle_r <= 22'd0;
                     out_neg_r   <= 1'b0;
                     out_err_r   <= 1'b0;
                     out_valid_r <= 1'b1;
                     state_r     <= DONE;
                  end else begin
                     state_r <= ALIGN;
                  end
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            ALIGN: begin
               r_r <= aligned_s;
               k_r <= KW'(MAX_EXP - 1);
`ifdef CORDIC_REDUCE_SKIP_EN
               if (aligned_s < TWO_PI) begin
                  state_r <= FOLD;
               end else begin
                  state_r <= REDUCE;
               end
`else
               state_r <= REDUCE;
`endif
            end
            REDUCE: begin
               r_r <= reduced_s;
               if (k_r == KW'(0)) begin
                  state_r <= FOLD;
               end else begin
                  k_r <= k_r - KW'(1);
               end
            end
            FOLD: begin
               out_angle_r <= angle_s;
               out_neg_r   <= neg_s;
               out_err_r   <= 1'b0;
               out_valid_r <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_angle = out_angle_r;
   assign bus.out_neg   = out_neg_r;
   assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_cordic_angle_reduce.sv
// Directed bench for cordic_angle_reduce: hand-computed angles, latency, backpressure and mid-flight reset.
module tb_cordic_angle_reduce;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests_run = 0;
   int   fail_cnt = 0;

`ifdef CORDIC_REDUCE_SKIP_EN
   localparam int LAT_SMALL = 3;
`else
   localparam int LAT_SMALL = 11;
`endif
   localparam int LAT_BIG = 11;
   localparam int LAT_ERR = 1;

   cordic_angle_reduce_if bus_if ();

   cordic_angle_reduce #(.MAX_EXP(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one angle, measure latency to out_valid, check result, then consume it.
   task automatic run_vec(input string tag, input logic [31:0] data, input int exp_angle,
                          input logic exp_neg, input logic exp_err, input int exp_lat);
      int n;
      check({tag, " in_ready"}, {31'd0, bus_if.in_ready}, 32'd1);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = data;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      n = 1;
      while (!bus_if.out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " latency"}, n, exp_lat);
      check({tag, " angle"}, {10'd0, bus_if.out_angle}, exp_angle);
      check({tag, " neg"}, {31'd0, bus_if.out_neg}, {31'd0, exp_neg});
      check({tag, " err"}, {31'd0, bus_if.out_err}, {31'd0, exp_err});
      check({tag, " busy"}, {31'd0, bus_if.in_ready}, 32'd0);
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.out_ready = 1'b0;
      check({tag, " consumed"}, {31'd0, bus_if.out_valid}, 32'd0);
   endtask

   initial begin
      int n;
      int seen;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = 32'd0;
      bus_if.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst in_ready", {31'd0, bus_if.in_ready}, 32'd1);
      check("rst out_valid", {31'd0, bus_if.out_valid}, 32'd0);
      check("rst angle", {10'd0, bus_if.out_angle}, 32'd0);
      check("rst neg", {31'd0, bus_if.out_neg}, 32'd0);
      check("rst err", {31'd0, bus_if.out_err}, 32'd0);

      run_vec("one",     32'h3F800000, 1048576, 1'b0, 1'b0, LAT_SMALL);
      run_vec("pi",      32'h40490FDB, 0,       1'b1, 1'b0, LAT_SMALL);
      run_vec("neg2",    32'hC0000000, 1197047, 1'b1, 1'b0, LAT_SMALL);
      run_vec("ten",     32'h41200000, 603164,  1'b1, 1'b0, LAT_BIG);
      run_vec("half",    32'h3F000000, 524288,  1'b0, 1'b0, LAT_SMALL);
      run_vec("hundred", 32'h42C80000, 556757,  1'b0, 1'b0, LAT_BIG);
      run_vec("max128",  32'h43000000, 844417,  1'b1, 1'b0, LAT_BIG);
      run_vec("inf",     32'h7F800000, 0,       1'b0, 1'b1, LAT_ERR);
      run_vec("nan",     32'h7FC00000, 0,       1'b0, 1'b1, LAT_ERR);
      run_vec("r256",    32'h43800000, 0,       1'b0, 1'b1, LAT_ERR);
      run_vec("denorm",  32'h00000001, 0,       1'b0, 1'b0, LAT_ERR);
      run_vec("negzero", 32'h80000000, 0,       1'b0, 1'b0, LAT_ERR);
      run_vec("exp98",   32'h31000000, 0,       1'b0, 1'b0, LAT_ERR);
      run_vec("exp99",   32'h31800000, 0,       1'b0, 1'b0, LAT_SMALL);

      // Backpressure: result must hold for 5 cycles and be consumed exactly once.
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 32'hC0000000;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      n = 1;
      while (!bus_if.out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("bp latency", n, LAT_SMALL);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp hold valid", {31'd0, bus_if.out_valid}, 32'd1);
         check("bp hold angle", {10'd0, bus_if.out_angle}, 32'd1197047);
         check("bp hold neg", {31'd0, bus_if.out_neg}, 32'd1);
         check("bp hold in_ready", {31'd0, bus_if.in_ready}, 32'd0);
      end
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.out_ready = 1'b0;
      check("bp consumed", {31'd0, bus_if.out_valid}, 32'd0);
      check("bp idle", {31'd0, bus_if.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("bp single", {31'd0, bus_if.out_valid}, 32'd0);

      // Reset while REDUCE is in progress must drop the operation.
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 32'h41200000;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid busy", {31'd0, bus_if.in_ready}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort in_ready", {31'd0, bus_if.in_ready}, 32'd1);
      check("abort out_valid", {31'd0, bus_if.out_valid}, 32'd0);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (bus_if.out_valid) seen++;
      end
      check("abort no stale", seen, 0);
      run_vec("after rst", 32'h3F800000, 1048576, 1'b0, 1'b0, LAT_SMALL);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
